// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver path: FSM state encoding and
// the oversampling clock divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_t;

   // Truncating divide, clamped so very fast baud settings still tick every clock.
   function automatic int baud_div(input int clk_hz, input int baud, input int os);
      int d;
      d = clk_hz / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, re-phased by
// clear. Shared by the UART receiver and transmitter.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic arst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver producing one-cycle byte strobes.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_byte_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int DIV    = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
   localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

   logic                 rx_meta, rx_sync, rx_prev;
   logic                 start_edge;
   logic                 tick;
   logic                 tick_clear;
   uart_rx_state_t       state;
   logic [SAMP_W-1:0]    samp_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_ok;

   // Synchroniser flops reset high so a released reset never looks like a start edge.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign start_edge = rx_prev & ~rx_sync;
   assign tick_clear = (state == IDLE) && start_edge;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .arst  (arst),
      .clear (tick_clear),
      .tick  (tick)
   );

`ifdef UART_RX_PARITY_EN
   logic parity_bit;
   logic par_err_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         parity_bit <= 1'b0;
      else if (state == PARITY && tick && samp_cnt == SAMP_LAST)
         parity_bit <= rx_sync;
   end

   assign parity_ok  = (parity_bit == ^shift_reg);
   assign parity_err = par_err_q;
`else
   assign parity_ok  = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= IDLE;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: pulses default low here and are only raised by the branch that
         // fires; non-blocking updates keep every register reading pre-edge values.
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start_edge) begin
                  samp_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= START;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (samp_cnt == SAMP_MID) begin
                     samp_cnt <= '0;
                     if (!rx_sync) begin
                        state <= DATA;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt  <= '0;
                     shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST)
                        state <= AFTER_DATA;
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt <= '0;
                     state    <= STOP;
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt  <= '0;
                     state     <= IDLE;
                     busy      <= 1'b0;
                     frame_err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                     par_err_q <= ~parity_ok;
`endif
                     if (rx_sync && parity_ok) begin
                        data_out <= shift_reg;
                        rx_done  <= 1'b1;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: directed frames plus randomized
// traffic at nominal and +/-3 % bit rates, compared against a frame-level model.
module tb_uart_byte_receiver;

   localparam int CLK_HZ = 16_000_000;
   localparam int BAUD   = 1_000_000;
   localparam int OS     = 16;
   localparam int DBITS  = 8;
   localparam int CLK_NS = 10;
   localparam int BIT_NS = CLK_NS * (CLK_HZ / BAUD);

   localparam logic [7:0] EV_DONE = 8'd1;
   localparam logic [7:0] EV_FERR = 8'd2;
   localparam logic [7:0] EV_PERR = 8'd3;

   logic             clk  = 1'b0;
   logic             arst = 1'b1;
   logic             rx   = 1'b1;
   logic [DBITS-1:0] data_out;
   logic             rx_done;
   logic             frame_err;
   logic             parity_err;
   logic             busy;

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   logic [7:0]  last_good = 8'h00;

   uart_byte_receiver #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .OVERSAMPLE  (OS),
      .DATA_BITS   (DBITS)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .rx         (rx),
      .data_out   (data_out),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #(CLK_NS / 2) clk = ~clk;

   // Record every flag pulse, once per cycle it is high, in arrival order.
   always @(negedge clk) begin
      if (!arst) begin
         if (rx_done)    got_q.push_back({EV_DONE, data_out});
         if (frame_err)  got_q.push_back({EV_FERR, 8'h00});
         if (parity_err) got_q.push_back({EV_PERR, 8'h00});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame-level reference: what a correct receiver reports for one frame.
   task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par);
      logic par_ok;
`ifdef UART_RX_PARITY_EN
      par_ok = (par == ^d);
`else
      par_ok = 1'b1;
`endif
      if (stop && par_ok) begin
         exp_q.push_back({EV_DONE, d});
         last_good = d;
      end
      if (!stop)   exp_q.push_back({EV_FERR, 8'h00});
      if (!par_ok) exp_q.push_back({EV_PERR, 8'h00});
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int bit_ns);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < DBITS; i++) begin
         rx = d[i];
         #(bit_ns);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      #(bit_ns);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      rx = stop;
      #(bit_ns);
   endtask

   task automatic idle(input int ns);
      rx = 1'b1;
      #(ns);
   endtask

   task automatic compare_events(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic settle_and_check(input string tag);
      idle(3 * BIT_NS);
      @(negedge clk);
      compare_events(tag);
      check({tag, "_data_out"}, data_out, last_good);
      check({tag, "_busy"}, busy, 1'b0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] d;
      logic       stop;
      logic       par;
      int         sel;
      int         bns;
      int         gap;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data_out",   data_out,   8'h00);
      check("rst_rx_done",    rx_done,    1'b0);
      check("rst_frame_err",  frame_err,  1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_busy",       busy,       1'b0);
      arst = 1'b0;
      repeat (4) @(posedge clk);
      #2;

      // Single good frame.
      expect_frame(8'hA5, 1'b1, ^8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5, BIT_NS);
      settle_and_check("single");

      // Back-to-back frames with no idle gap.
      expect_frame(8'h01, 1'b1, ^8'h01);
      expect_frame(8'h00, 1'b1, ^8'h00);
      expect_frame(8'h00, 1'b1, ^8'h00);
      expect_frame(8'h13, 1'b1, ^8'h13);
      send_frame(8'h01, 1'b1, ^8'h01, BIT_NS);
      send_frame(8'h00, 1'b1, ^8'h00, BIT_NS);
      send_frame(8'h00, 1'b1, ^8'h00, BIT_NS);
      send_frame(8'h13, 1'b1, ^8'h13, BIT_NS);
      settle_and_check("b2b");
      last_good = 8'hA5;
      expect_frame(8'hA5, 1'b1, ^8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5, BIT_NS);
      settle_and_check("reload");

      // Short glitch: START entered, then abandoned at mid-bit.
      rx = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_hi", busy, 1'b1);
      @(posedge clk);
      #2;
      rx = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_lo", busy, 1'b0);
      @(posedge clk);
      #2;
      settle_and_check("glitch");

      // Framing error, then the line stays low: no new start may be seen.
      expect_frame(8'h3C, 1'b0, ^8'h3C);
      send_frame(8'h3C, 1'b0, ^8'h3C, BIT_NS);
      #(20 * BIT_NS);
      @(negedge clk);
      check("held_low_busy", busy, 1'b0);
      @(posedge clk);
      #2;
      settle_and_check("frame_err");

      // Reset in the middle of data bit 3, then a clean frame.
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         #(BIT_NS);
      end
      rx = 1'b1;
      #(BIT_NS / 2);
      @(negedge clk);
      check("mid_busy", busy, 1'b1);
      arst = 1'b1;
      @(negedge clk);
      check("arst_data_out",   data_out,   8'h00);
      check("arst_rx_done",    rx_done,    1'b0);
      check("arst_frame_err",  frame_err,  1'b0);
      check("arst_parity_err", parity_err, 1'b0);
      check("arst_busy",       busy,       1'b0);
      @(negedge clk);
      arst = 1'b0;
      last_good = 8'h00;
      idle(8 * BIT_NS);
      @(posedge clk);
      #2;
      expect_frame(8'h55, 1'b1, ^8'h55);
      send_frame(8'h55, 1'b1, ^8'h55, BIT_NS);
      settle_and_check("after_arst");

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones, so even parity requires a parity bit of 1.
      expect_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0, BIT_NS);
      settle_and_check("par_bad");
      expect_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1, BIT_NS);
      settle_and_check("par_good");
`endif

      // Randomized traffic at nominal and +/-3 % bit periods.
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         par  = (^d) ^ ($urandom_range(0, 4) == 0);
         sel  = $urandom_range(0, 2);
         bns  = (sel == 0) ? BIT_NS - 5 : (sel == 1) ? BIT_NS : BIT_NS + 5;
         expect_frame(d, stop, par);
         send_frame(d, stop, par, bns);
         gap  = (bns == BIT_NS && stop) ? $urandom_range(0, 2) : $urandom_range(1, 2);
         idle(gap * BIT_NS);
         @(posedge clk);
         #2;
      end
      settle_and_check("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
